fetch: RTL and testbench

Instruction fetch stage; produces the instruction/PC pair consumed by the decode stage. Holds the fetch PC and issues word requests on a request/grant instruction-memory port with in-order responses. Buffers returned words in a small FIFO and presents them to decode through registered outputs, honouring decode stalls. Squashes the in-flight stream on an execute-stage redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch.sv | 150 +++++++++++++++
 tb/tb_fetch.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Entry layout, NOP word, JAL opcode and J-immediate decode.
package fetch_pkg;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [6:0]  OPC_JAL = 7'b1101111;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pred;
   } fetch_entry_t;

   function automatic logic [31:0] imm_j(input logic [31:0] ins);
      return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/grant port.
// Responses return in order, at least one cycle after grant.
interface fetch_if;

   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;

   modport master (
      output o_imem_req,
      output o_imem_addr,
      input  i_imem_gnt,
      input  i_imem_rvalid,
      input  i_imem_rdata
   );

   modport slave (
      input  o_imem_req,
      input  o_imem_addr,
      output i_imem_gnt,
      output i_imem_rvalid,
      output i_imem_rdata
   );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer between imem and decode.
// Flush empties it; push and pop may coincide when full.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_flush,
   input  logic          i_push,
   input  fetch_entry_t  i_data,
   input  logic          i_pop,
   output fetch_entry_t  o_data,
   output logic [CW-1:0] o_count,
   output logic          o_empty
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign do_pop  = i_pop && (cnt_q != '0);
   assign do_push = i_push &&
                    ((cnt_q != CW'(DEPTH)) || do_pop);
   assign o_data  = mem_q[rd_q];
   assign o_count = cnt_q;
   assign o_empty = (cnt_q == '0);

   // next pointers and occupancy; flush wins
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (i_flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   // storage; slots beyond the count are don't-care
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_q] <= i_data;
   end

   // pointer and count registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fetch.sv
// fetch: PC, imem requests, buffer and decode output regs.
// Define FETCH_JAL_PREDICT_EN to let fetch follow JALs itself.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   fetch_if.master     imem,
   input  logic        i_dec_stall,
   input  logic        i_exec_redirect,
   input  logic [31:0] i_exec_target,
   output logic [31:0] b_fetch_dec_instr,
   output logic [31:0] b_fetch_dec_pc,
   output logic        b_fetch_dec_valid,
   output logic        b_fetch_dec_pred_taken
);

`ifdef FETCH_JAL_PREDICT_EN
   localparam bit JAL_EN = 1'b1;
`else
   localparam bit JAL_EN = 1'b0;
`endif
   localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CAP   = (CW+1)'(FIFO_DEPTH);
   localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

   logic          run_q;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rpc_q, rpc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] disc_q, disc_d;
   logic          valid_q, valid_d;
   fetch_entry_t  out_q, out_d;

   fetch_entry_t  head, rsp_e, cand;
   logic [CW-1:0] f_count;
   logic          f_empty;
   logic [CW:0]   occ;
   logic          req, gnt, rsp_ok, ld, avail;
   logic          bypass, jal, redir, push, pop;
   logic [31:0]   redir_pc;

   // requests stop once in-flight plus buffered fills the FIFO
   assign occ = {1'b0, outst_q} + {1'b0, f_count};
   assign req = run_q && (disc_q == '0) && (occ < CAP);
   assign gnt = req && imem.i_imem_gnt;

   assign imem.o_imem_req  = req;
   assign imem.o_imem_addr = pc_q;

   assign rsp_ok = imem.i_imem_rvalid && (disc_q == '0) &&
                   !i_exec_redirect;
   assign rsp_e  = '{instr: imem.i_imem_rdata,
                     pc:    rpc_q,
                     pred:  1'b0};
   assign cand   = f_empty ? rsp_e : head;

   assign ld     = !i_dec_stall || !valid_q;
   assign avail  = !f_empty || rsp_ok;
   assign bypass = f_empty && rsp_ok && ld;
   assign pop    = ld && !f_empty && !i_exec_redirect;

   // a JAL entering the output reg squashes what follows it
   assign jal    = JAL_EN && ld && avail && !i_exec_redirect &&
                   (cand.instr[6:0] == OPC_JAL);
   assign redir  = i_exec_redirect || jal;
   assign push   = rsp_ok && !bypass && !jal;

   assign redir_pc = (i_exec_redirect ? i_exec_target
                      : cand.pc + imm_j(cand.instr)) & ALIGN;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (redir),
      .i_push  (push),
      .i_data  (rsp_e),
      .i_pop   (pop),
      .o_data  (head),
      .o_count (f_count),
      .o_empty (f_empty)
   );

   // next state; redirect applied last so it overrides
   always_comb begin
      pc_d    = pc_q;
      rpc_d   = rpc_q;
      disc_d  = disc_q;
      valid_d = valid_q;
      out_d   = out_q;
      outst_d = outst_q + CW'(gnt) -
                CW'(imem.i_imem_rvalid);
      if (gnt)    pc_d  = pc_q + 32'd4;
      if (rsp_ok) rpc_d = rpc_q + 32'd4;
      if (imem.i_imem_rvalid && (disc_q != '0))
         disc_d = disc_q - CW'(1);
      if (ld) begin
         valid_d = avail;
         if (avail) begin
            out_d      = cand;
            out_d.pred = jal;
         end else begin
            out_d.instr = NOP;
            out_d.pred  = 1'b0;
         end
      end
      if (redir) begin
         pc_d   = redir_pc;
         rpc_d  = redir_pc;
         disc_d = outst_d;
      end
      if (i_exec_redirect) begin
         valid_d     = 1'b0;
         out_d.instr = NOP;
         out_d.pred  = 1'b0;
      end
   end

   // state registers; reset drops all in-flight state
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         run_q   <= 1'b0;
         pc_q    <= RESET_PC & ALIGN;
         rpc_q   <= RESET_PC & ALIGN;
         outst_q <= '0;
         disc_q  <= '0;
         valid_q <= 1'b0;
         out_q   <= '{instr: NOP, pc: 32'h0, pred: 1'b0};
      end else begin
         run_q   <= 1'b1;
         pc_q    <= pc_d;
         rpc_q   <= rpc_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

   assign b_fetch_dec_instr      = out_q.instr;
   assign b_fetch_dec_pc         = out_q.pc;
   assign b_fetch_dec_valid      = valid_q;
   assign b_fetch_dec_pred_taken = JAL_EN && out_q.pred;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of fetch with a 1-cycle imem model.
// Memory word at A is A ^ 32'h5A00_0000, except a JAL at 0x40.
`timescale 1ns/1ps
module tb_fetch;
   import fetch_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] target = 32'h0;
   logic [31:0] instr, pc;
   logic        valid, pred;

   int checks = 0;
   int errors = 0;

   int          cyc = 0;
   bit          hold = 1'b0;
   bit          gnt_en = 1'b1;
   logic [31:0] q_addr [$];
   int          q_due [$];

   fetch_if imem ();

   fetch #(
      .RESET_PC   (32'h0000_0100),
      .FIFO_DEPTH (2)
   ) dut (
      .i_clk                  (i_clk),
      .i_rst_n                (i_rst_n),
      .imem                   (imem),
      .i_dec_stall            (stall),
      .i_exec_redirect        (redirect),
      .i_exec_target          (target),
      .b_fetch_dec_instr      (instr),
      .b_fetch_dec_pc         (pc),
      .b_fetch_dec_valid      (valid),
      .b_fetch_dec_pred_taken (pred)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      if (a == 32'h40) return 32'h0080_006F;
      return a ^ 32'h5A00_0000;
   endfunction

   // imem model: acts 1ns after the falling edge
   initial begin
      imem.i_imem_gnt    = 1'b0;
      imem.i_imem_rvalid = 1'b0;
      imem.i_imem_rdata  = '0;
      forever begin
         @(negedge i_clk);
         #1;
         cyc++;
         imem.i_imem_rvalid = 1'b0;
         imem.i_imem_rdata  = '0;
         if (!i_rst_n) begin
            q_addr.delete();
            q_due.delete();
         end else if (!hold && q_addr.size() > 0 &&
                      q_due[0] <= cyc) begin
            imem.i_imem_rvalid = 1'b1;
            imem.i_imem_rdata  = word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end
         imem.i_imem_gnt = gnt_en;
         if (i_rst_n && imem.o_imem_req && gnt_en) begin
            q_addr.push_back(imem.o_imem_addr);
            q_due.push_back(cyc + 1);
         end
      end
   end

   task automatic step();
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if (imem.o_imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_req got %b exp 0", imem.o_imem_req);
      end
      checks++;
      if ({valid, pred} !== 2'b00) begin
         errors++;
         $display("FAIL reset_valid_pred got %b%b exp 00",
                  valid, pred);
      end
      checks++;
      if ({instr, pc} !== {NOP, 32'h0}) begin
         errors++;
         $display("FAIL reset_out got %h/%h exp %h/0",
                  instr, pc, NOP);
      end
   endtask

   task automatic test_sequential();
      i_rst_n = 1'b1;
      step();
      checks++;
      if ({imem.o_imem_req, imem.o_imem_addr} !==
          {1'b1, 32'h100}) begin
         errors++;
         $display("FAIL first_req got %b/%h exp 1/100",
                  imem.o_imem_req, imem.o_imem_addr);
      end
      step();
      checks++;
      if (imem.o_imem_addr !== 32'h104) begin
         errors++;
         $display("FAIL addr_after_gnt got %h exp 104",
                  imem.o_imem_addr);
      end
      step();
      for (int k = 0; k < 4; k++) begin
         logic [31:0] e;
         e = 32'h100 + 32'(4 * k);
         checks++;
         if ({valid, pc, instr} !== {1'b1, e, word(e)}) begin
            errors++;
            $display("FAIL seq_%0d got %b/%h/%h exp 1/%h/%h",
                     k, valid, pc, instr, e, word(e));
         end
         step();
      end
   endtask

   task automatic test_stall();
      logic [31:0] cpc, cin, e;
      int got = 0;
      step();
      cpc = pc;
      cin = instr;
      checks++;
      if (valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_pre_valid got %b exp 1", valid);
      end
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if ({valid, pc, instr} !== {1'b1, cpc, cin}) begin
            errors++;
            $display("FAIL stall_hold_%0d got %b/%h/%h exp 1/%h/%h",
                     k, valid, pc, instr, cpc, cin);
         end
      end
      checks++;
      if (imem.o_imem_req !== 1'b0) begin
         errors++;
         $display("FAIL stall_req got %b exp 0", imem.o_imem_req);
      end
      stall = 1'b0;
      e = cpc + 32'd4;
      for (int k = 0; k < 12 && got < 4; k++) begin
         step();
         if (valid) begin
            checks++;
            if ({pc, instr} !== {e, word(e)}) begin
               errors++;
               $display("FAIL stall_release_%0d got %h/%h exp %h/%h",
                        got, pc, instr, e, word(e));
            end
            e = e + 32'd4;
            got++;
         end
      end
      checks++;
      if (got != 4) begin
         errors++;
         $display("FAIL stall_release_count got %0d exp 4", got);
      end
   endtask

   task automatic test_redirect_same_cycle();
      repeat (3) step();
      checks++;
      if (imem.o_imem_req !== 1'b1) begin
         errors++;
         $display("FAIL rsc_pre_req got %b exp 1", imem.o_imem_req);
      end
      redirect = 1'b1;
      target   = 32'h3000;
      step();
      redirect = 1'b0;
      checks++;
      if ({valid, instr, imem.o_imem_req} !==
          {1'b0, NOP, 1'b0}) begin
         errors++;
         $display("FAIL rsc_squash got %b/%h/%b exp 0/%h/0",
                  valid, instr, imem.o_imem_req, NOP);
      end
      step();
      checks++;
      if ({imem.o_imem_req, imem.o_imem_addr} !==
          {1'b1, 32'h3000}) begin
         errors++;
         $display("FAIL rsc_req got %b/%h exp 1/3000",
                  imem.o_imem_req, imem.o_imem_addr);
      end
      repeat (2) step();
      checks++;
      if ({valid, pc, instr} !==
          {1'b1, 32'h3000, word(32'h3000)}) begin
         errors++;
         $display("FAIL rsc_first got %b/%h/%h exp 1/3000/%h",
                  valid, pc, instr, word(32'h3000));
      end
      step();
      checks++;
      if ({valid, pc} !== {1'b1, 32'h3004}) begin
         errors++;
         $display("FAIL rsc_second got %b/%h exp 1/3004", valid, pc);
      end
   endtask

   task automatic test_redirect_outstanding();
      repeat (3) step();
      hold = 1'b1;
      repeat (2) step();
      checks++;
      if (imem.o_imem_req !== 1'b0) begin
         errors++;
         $display("FAIL ro_cap_req got %b exp 0", imem.o_imem_req);
      end
      redirect = 1'b1;
      target   = 32'h2003;
      step();
      redirect = 1'b0;
      hold     = 1'b0;
      checks++;
      if ({valid, instr} !== {1'b0, NOP}) begin
         errors++;
         $display("FAIL ro_squash got %b/%h exp 0/%h",
                  valid, instr, NOP);
      end
      step();
      checks++;
      if (imem.o_imem_req !== 1'b0) begin
         errors++;
         $display("FAIL ro_discard_req got %b exp 0",
                  imem.o_imem_req);
      end
      step();
      checks++;
      if ({imem.o_imem_req, imem.o_imem_addr, valid} !==
          {1'b1, 32'h2000, 1'b0}) begin
         errors++;
         $display("FAIL ro_req got %b/%h/%b exp 1/2000/0",
                  imem.o_imem_req, imem.o_imem_addr, valid);
      end
      repeat (2) step();
      checks++;
      if ({valid, pc, instr} !==
          {1'b1, 32'h2000, word(32'h2000)}) begin
         errors++;
         $display("FAIL ro_first got %b/%h/%h exp 1/2000/%h",
                  valid, pc, instr, word(32'h2000));
      end
   endtask

   task automatic test_gnt_low();
      logic [31:0] a;
      repeat (3) step();
      a = imem.o_imem_addr;
      gnt_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if ({imem.o_imem_req, imem.o_imem_addr} !== {1'b1, a}) begin
            errors++;
            $display("FAIL gnt_low_addr_%0d got %b/%h exp 1/%h",
                     k, imem.o_imem_req, imem.o_imem_addr, a);
         end
      end
      checks++;
      if ({valid, instr} !== {1'b0, NOP}) begin
         errors++;
         $display("FAIL gnt_low_drain got %b/%h exp 0/%h",
                  valid, instr, NOP);
      end
      gnt_en = 1'b1;
      repeat (2) step();
      checks++;
      if ({valid, pc, instr} !== {1'b1, a, word(a)}) begin
         errors++;
         $display("FAIL gnt_resume got %b/%h/%h exp 1/%h/%h",
                  valid, pc, instr, a, word(a));
      end
   endtask

   task automatic test_jal();
      logic [31:0] epc [4];
      logic        epr [4];
      int got = 0;
      epc[0] = 32'h38;
      epc[1] = 32'h3C;
      epc[2] = 32'h40;
      epr[0] = 1'b0;
      epr[1] = 1'b0;
      epr[3] = 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
      epc[3] = 32'h48;
      epr[2] = 1'b1;
`else
      epc[3] = 32'h44;
      epr[2] = 1'b0;
`endif
      repeat (2) step();
      redirect = 1'b1;
      target   = 32'h38;
      step();
      redirect = 1'b0;
      for (int k = 0; k < 20 && got < 4; k++) begin
         if (valid) begin
            checks++;
            if ({pc, instr, pred} !==
                {epc[got], word(epc[got]), epr[got]}) begin
               errors++;
               $display("FAIL jal_%0d got %h/%h/%b exp %h/%h/%b",
                        got, pc, instr, pred,
                        epc[got], word(epc[got]), epr[got]);
            end
            got++;
         end
         step();
      end
      checks++;
      if (got != 4) begin
         errors++;
         $display("FAIL jal_count got %0d exp 4", got);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_same_cycle();
      test_redirect_outstanding();
      test_gnt_low();
      test_jal();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
